adder_operand_sequencer: RTL and testbench

- Upstream control stage for the 64-bit fast adder/subtractor (`fast_adder_ques1`).
- Accepts operation requests over a valid/ready handshake and drives the adder's `a`, `b` and `operation` inputs, holding them stable.
- Waits a fixed adder latency, then captures `sum`/`carry`, computes status flags and presents the result downstream with valid/ready.
- Replaces free-running testbench stimulus with a registered, back-pressured operand path.

---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/adder_flag_calc.sv | 27 ++
 rtl/adder_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder operand sequencer.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/adder_flag_calc.sv
// Combinational status flags for an adder/subtractor result.
module adder_flag_calc
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             op,
    input  logic [WIDTH-1:0] sum,
    output logic             zero_c,
    output logic             neg_c,
    output logic             ovf_c
);

    // Zero/negative from the result; overflow from operand and result signs.
    always_comb begin
        zero_c = (sum == '0);
        neg_c  = sum[WIDTH-1];
        if (op == OP_ADD) begin
            ovf_c = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
        end else begin
            ovf_c = (a_msb != b_msb) && (sum[WIDTH-1] != a_msb);
        end
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Registered, back-pressured operand and result path around a fixed-latency adder.
module adder_operand_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_op,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_op,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_carry,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_ovf,
    output logic [COUNT_W-1:0]   op_count
);

    // Cleared on entry to WAIT, so it never needs to count past LATENCY.
    localparam int unsigned CNT_W = $clog2(LATENCY + 2);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               capture;
    logic               consume;
    logic               flag_zero;
    logic               flag_neg;
    logic               flag_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)                    next_state = WAIT;
            WAIT:    if (cnt == CNT_W'(LATENCY))      next_state = DONE;
            DONE:    if (out_ready)                   next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
    end

    // Handshake outputs and datapath enables decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            WAIT: begin
                capture = (cnt == CNT_W'(LATENCY));
            end
            DONE: begin
                out_valid = 1'b1;
                consume   = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Flags are derived from the operands currently held at the adder.
    adder_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .a_msb  (add_a[WIDTH-1]),
        .b_msb  (add_b[WIDTH-1]),
        .op     (add_op),
        .sum    (add_sum),
        .zero_c (flag_zero),
        .neg_c  (flag_neg),
        .ovf_c  (flag_ovf)
    );

    // Wait counter: cleared on acceptance, advances while waiting for the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == WAIT && !capture) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand registers: load only on acceptance, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a  <= '0;
            add_b  <= '0;
            add_op <= OP_ADD;
        end else if (accept) begin
            add_a  <= in_a;
            add_b  <= in_b;
            add_op <= in_op;
        end
    end

    // Result registers: load once the adder latency has elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (capture) begin
            out_sum   <= add_sum;
            out_carry <= add_carry;
            out_zero  <= flag_zero;
            out_neg   <= flag_neg;
            out_ovf   <= flag_ovf;
        end
    end

    // Completed output handshakes, wrapping at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (consume) begin
            op_count <= op_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed self-checking bench for adder_operand_sequencer with a behavioural one-stage adder.
module tb_adder_operand_sequencer;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned LATENCY = 1;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_op;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_op;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_carry;
    logic               out_zero;
    logic               out_neg;
    logic               out_ovf;
    logic [15:0]        op_count;

    int errors = 0;
    int checks = 0;

    adder_operand_sequencer #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_op    (add_op),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-register adder stand-in: sum/carry valid one edge after operands.
    logic [WIDTH:0] adder_res;
    always_comb begin
        if (add_op) adder_res = {1'b0, add_a} + {1'b0, ~add_b} + 65'd1;
        else        adder_res = {1'b0, add_a} + {1'b0, add_b};
    end
    always_ff @(posedge clk) begin
        {add_carry, add_sum} <= adder_res;
    end

    // Present one request at a negedge while idle; lat = edges from accept to out_valid seen.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic op, output int lat);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_op !== 1'b0 || out_sum !== '0) begin
            errors++; $display("FAIL reset_data: add_a=%h add_b=%h add_op=%b out_sum=%h expected all 0", add_a, add_b, add_op, out_sum);
        end
        checks++;
        if ({out_carry, out_zero, out_neg, out_ovf} !== 4'b0 || op_count !== 16'd0) begin
            errors++; $display("FAIL reset_flags: flags=%b op_count=%0d expected 0000/0", {out_carry, out_zero, out_neg, out_ovf}, op_count);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle: in_ready=%b expected 1", in_ready);
        end
    endtask

    // Generic directed vector: checks latency, result, flags, and count after the handshake.
    task automatic test_vector(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic op, input logic [WIDTH-1:0] exp_sum, input logic [3:0] exp_czno,
                               input logic [15:0] exp_count);
        int lat;
        run_op(a, b, op, lat);
        checks++;
        if (lat != int'(LATENCY) + 1) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY + 1);
        end
        checks++;
        if (out_sum !== exp_sum) begin
            errors++; $display("FAIL %s_sum: got %h expected %h", name, out_sum, exp_sum);
        end
        checks++;
        if ({out_carry, out_zero, out_neg, out_ovf} !== exp_czno) begin
            errors++; $display("FAIL %s_flags: carry/zero/neg/ovf got %b expected %b", name, {out_carry, out_zero, out_neg, out_ovf}, exp_czno);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_count) begin
            errors++; $display("FAIL %s_handshake: out_valid=%b in_ready=%b op_count=%0d expected 0/1/%0d", name, out_valid, in_ready, op_count, exp_count);
        end
        checks++;
        if (add_a !== a || add_b !== b || add_op !== op) begin
            errors++; $display("FAIL %s_operand_hold: add_a=%h add_b=%h add_op=%b expected %h %h %b", name, add_a, add_b, add_op, a, b, op);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(64'd5, 64'd5, 1'b1, lat);
        checks++;
        if (lat != int'(LATENCY) + 1 || out_sum !== '0 || {out_carry, out_zero, out_neg, out_ovf} !== 4'b1100) begin
            errors++; $display("FAIL bp_result: lat=%0d sum=%h flags=%b expected %0d/0/1100", lat, out_sum, {out_carry, out_zero, out_neg, out_ovf}, LATENCY + 1);
        end
        in_valid = 1'b1; in_a = 64'hDEAD; in_b = 64'hBEEF; in_op = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== '0 || out_zero !== 1'b1 ||
                out_carry !== 1'b1 || add_a !== 64'd5 || op_count !== 16'd3) begin
                errors++; $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%h zero=%b carry=%b add_a=%h count=%0d", i, out_valid, in_ready, out_sum, out_zero, out_carry, add_a, op_count);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (op_count !== 16'd4 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: op_count=%0d in_ready=%b out_valid=%b expected 4/1/0", op_count, in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_sum [2];
        int acc = 0, busy = 0, nres = 0;
        exp_sum[0] = 64'd3;
        exp_sum[1] = 64'd7;
        in_a = 64'd1; in_b = 64'd2; in_op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && nres < 2; c++) begin
            if (out_valid) begin
                checks++;
                if (out_sum !== exp_sum[nres]) begin
                    errors++; $display("FAIL b2b_sum_%0d: got %h expected %h", nres, out_sum, exp_sum[nres]);
                end
                nres++;
            end
            if (in_valid && in_ready) acc++;
            else if (acc == 1) busy++;
            @(negedge clk);
            if (acc == 1) begin in_a = 64'd10; in_b = 64'd3; in_op = 1'b1; end
            if (acc == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (nres != 2 || acc != 2) begin
            errors++; $display("FAIL b2b_progress: results=%0d accepts=%0d expected 2/2", nres, acc);
        end
        checks++;
        if (busy != int'(LATENCY) + 2) begin
            errors++; $display("FAIL b2b_spacing: busy cycles=%0d expected %0d", busy, LATENCY + 2);
        end
        checks++;
        if (op_count !== 16'd6 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_count: op_count=%0d out_valid=%b expected 6/0", op_count, out_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen = 1'b0;
        in_a = 64'd9; in_b = 64'd4; in_op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstw_inwait: in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'd0 || add_a !== '0) begin
            errors++; $display("FAIL rstw_after: in_ready=%b out_valid=%b op_count=%0d add_a=%h expected 1/0/0/0", in_ready, out_valid, op_count, add_a);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0 || op_count !== 16'd0) begin
            errors++; $display("FAIL rstw_discard: out_valid_seen=%b op_count=%0d expected 0/0", seen, op_count);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = 1'b0;
        @(negedge clk);
        test_reset();
        test_vector("sub_basic", 64'h111, 64'h10, 1'b1, 64'h101, 4'b1000, 16'd1);
        test_vector("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0011, 16'd2);
        test_vector("sub_neg", 64'h10, 64'h111, 1'b1, 64'hFFFF_FFFF_FFFF_FEFF, 4'b0010, 16'd3);
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
